// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_pkg
// Purpose : Shared types, constants and PC helpers for the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic        RST_ENABLED        = 1'b0;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0040_0004;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Instruction-memory request/ready handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Purpose : IF/ID pipeline register; flush beats load beats hold.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         load,
    input  wire         flush,
    input  wire  [31:0] load_instr,
    input  wire  [31:0] load_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    logic        valid_q,    valid_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = load_instr;
            pc_d       = load_pc;
            pc_plus4_d = pc_plus4(load_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc_plus4_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Purpose : MIPS IF stage: PC, imem handshake FSM, skid buffer, IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  stall,
    input  wire                  is_branch,
    input  wire  [31:0]          branch_target,
    input  wire                  exception,
    fetch_stage_if.master        imem,
    output logic [31:0]          pc_out,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         req;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc;

    // A stalled branch is still sitting in ID, so only exceptions redirect under stall.
    assign redirect        = exception | (is_branch & ~stall);
    assign redirect_target = exception ? EXC_VECTOR : word_align(branch_target);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        req           = 1'b0;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr    = imem.imem_rdata;
        ifid_pc       = pc_q;

        if (redirect) begin
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = 32'h0;
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_d       = redirect_target;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    req = 1'b1;
                    if (imem.imem_ready) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4(pc_q);
                    end else begin
                        state_d    = ST_WAIT;
                        ifid_flush = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (redirect) begin
                    redirect_pc_d = redirect_target;
                    state_d       = ST_DRAIN;
                    ifid_flush    = 1'b1;
                end else if (imem.imem_ready) begin
                    pc_d = pc_plus4(pc_q);
                    if (!stall) begin
                        ifid_load = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The in-flight word is wrong-path; only an exception may retarget.
                req        = 1'b1;
                ifid_flush = 1'b1;
                if (exception) begin
                    redirect_pc_d = EXC_VECTOR;
                end
                if (imem.imem_ready) begin
                    pc_d    = exception ? EXC_VECTOR : redirect_pc_q;
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_target;
                    ifid_flush = 1'b1;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_instr   = skid_instr_q;
                    ifid_pc      = skid_pc_q;
                    skid_instr_d = NOP_INSTR;
                    skid_pc_d    = 32'h0;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    assign imem.imem_req  = req & (rst != RST_ENABLED);
    assign imem.imem_addr = pc_q;
    assign pc_out         = pc_q;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .load_instr  (ifid_instr),
        .load_pc     (ifid_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the static 5-stage MIPS pipeline; sits directly upstream of the ID-stage branch comparator.
- Owns the PC and issues word requests to instruction memory over a req/ready handshake.
- Consumes the comparator's is_branch and the ID-computed target to redirect fetch, and flushes the wrong-path instruction.
- No delay slot: a taken branch squashes the instruction fetched behind it.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0040_0004, PC loaded on exception redirect.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- is_branch  in  1  taken-branch/jump indication from ID comparator.
- branch_target  in  32  redirect PC from ID; bits [1:0] ignored.
- exception  in  1  redirect to EXC_VECTOR; highest priority.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; [1:0]=00.
- imem_ready  in  1  memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  in  32  instruction word.
- pc_out  out  32  current IF PC (debug/trace).
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  IF/ID instruction; 0 (nop) when invalid.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc+4, for JAL link and branch-target adders.

Behaviour:
- Reset is sampled on the clk edge while rst=0:
  - pc=RESET_PC, state=FETCH, skid buffer empty.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
  - imem_req=0 while rst=0.
  - Reset mid-request abandons the request; any late imem_ready is ignored until a new request is issued.
- States:
  - FETCH: may issue a request.
  - WAIT: request outstanding.
  - DRAIN: request outstanding, result to be discarded.
  - HOLD: result parked in the skid buffer.
- Redirect priority: exception > (is_branch & ~stall) > sequential.
  - is_branch is ignored while stall=1, because the branch instruction is held in ID.
  - exception is honoured regardless of stall.
- Redirect target: exception uses EXC_VECTOR; branch uses {branch_target[31:2],2'b00}.
- On a redirect cycle:
  - IF/ID is flushed next edge: id_valid=0, id_instr=0.
  - The skid buffer is cleared.
- FETCH state:
  - imem_req=1 iff stall=0 and no redirect this cycle; imem_addr=pc.
  - Redirect: pc<=target, no request issued this cycle; fetch resumes the next cycle.
  - Request with imem_ready=1 (zero-wait memory): IF/ID<={1, imem_rdata, pc, pc+4}, pc<=pc+4, stay FETCH.
  - Request with imem_ready=0: go WAIT; IF/ID gets a bubble (id_valid=0).
  - stall=1: PC and IF/ID hold.
- WAIT state (imem_req=1, imem_addr held stable at pc):
  - Redirect: latch target into redirect_pc, go DRAIN; IF/ID flushed.
  - ready & ~stall: load IF/ID, pc<=pc+4, go FETCH.
  - ready & stall: capture {imem_rdata, pc} into skid buffer, pc<=pc+4, go HOLD.
  - ~ready: IF/ID gets a bubble if ~stall, else holds.
- DRAIN state (imem_req=1, imem_addr=old pc):
  - A later exception overwrites redirect_pc with EXC_VECTOR; a branch does not.
  - On ready: discard imem_rdata, pc<=redirect_pc, go FETCH.
  - id_valid stays 0 throughout.
- HOLD state (imem_req=0):
  - On ~stall: skid contents move to IF/ID, go FETCH.
  - On redirect: skid cleared, pc<=target, go FETCH.
- Arithmetic: all PC increments are modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Timing: pc_out=pc, registered; IF/ID outputs are registered (1-cycle latency from imem_ready).
- Invariant: an instruction enters IF/ID at most once and in program order.

Decomposition:
- Shared defines header:
  - `RST_ENABLED (1'b0) and the state encodings FETCH/WAIT/DRAIN/HOLD.
  - Macros for RESET_PC / EXC_VECTOR defaults.
  - NOP_INSTR (32'h0).
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush controls.
- The PC register, FSM and skid buffer stay in fetch_stage.

Test Plan:
- Zero-wait sequential fetch: rst low 2 cycles, then imem_ready tied 1 -> imem_addr steps 0x00400000, 04, 08; id_pc lags by 1 cycle; id_pc_plus4=id_pc+4.
- Taken branch: id_instr at 0x00400008, is_branch=1, branch_target=0x00400100 -> next edge id_valid=0; next request addr 0x00400100; 0x0040000C never reaches id_valid=1.
- Redirect during wait: ready=0 for 3 cycles at addr 0x00400010, branch to 0x00400200 in cycle 1 -> addr held at 0x00400010 until ready; data discarded; next addr 0x00400200.
- Stall with skid: ready arrives at addr 0x00400020 while stall=1 for 2 cycles -> IF/ID unchanged during stall; the cycle after stall drops, id_pc=0x00400020 with the returned word; the next request addr is 0x00400024, issued only after the skid entry has moved into IF/ID (no duplicate, no loss).
- Priority: exception=1 and is_branch=1 together (target 0x00400300) -> pc=0x00400004, IF/ID flushed. is_branch=1 with stall=1 -> ignored, PC unchanged.
- Reset mid-request and wrap: rst=0 while in WAIT -> imem_req=0, pc=0x00400000, id_valid=0. Separately, branch to 0xFFFFFFFC with zero-wait memory -> next addr 0x00000000.
